// File: rtl/mips_debug_controller_if.sv
// Byte stream with valid/ready handshake, used for the UART receive and transmit sides.
interface mips_debug_controller_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/mips_debug_controller.sv
// Run-control and debug-word readout sequencer between the UART and the MIPS pipeline.
// Halts, free-runs or single-steps the pipeline and returns a selected 32-bit word as 4 bytes.
module mips_debug_controller #(
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_debug_controller_if.slave  rx,
    mips_debug_controller_if.master tx,
    output logic                    pipe_en,
    input  logic                    pipe_halt,
    output logic [5:0]              dbg_sel,
    input  logic [31:0]             dbg_data,
    output logic [CNT_W-1:0]        cycle_count,
    output logic                    running
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_LATCH, S_SEND} state_t;
    typedef enum logic [1:0] {OP_HALT = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_READ = 2'b11} op_t;

    state_t      state, state_nxt;
    logic [6:0]  step_cnt, step_cnt_nxt;
    logic [31:0] shift, shift_nxt;
    logic [1:0]  byte_cnt, byte_cnt_nxt;
    logic [5:0]  dbg_sel_nxt;
    logic        en_nxt;
    logic        accept;
    op_t         op;

    assign rx.ready = (state == S_IDLE) || (state == S_RUN);
    assign accept   = rx.valid && rx.ready;
    assign op       = op_t'(rx.data[7:6]);

    // Transmit outputs decode straight from state/shift so reset clears them asynchronously.
    assign tx.valid = (state == S_SEND);
    assign tx.data  = shift[7:0];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt    = state;
        step_cnt_nxt = step_cnt;
        shift_nxt    = shift;
        byte_cnt_nxt = byte_cnt;
        dbg_sel_nxt  = dbg_sel;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_RUN: if (!pipe_halt) state_nxt = S_RUN;
                        OP_STEP: begin
                            if (!pipe_halt) begin
                                state_nxt    = S_STEP;
                                step_cnt_nxt = {1'b0, rx.data[5:0]} + 7'd1;
                            end
                        end
                        OP_READ: begin
                            dbg_sel_nxt = rx.data[5:0];
                            state_nxt   = S_LATCH;
                        end
                        OP_HALT: ;
                    endcase
                end
            end
            S_RUN: begin
                if (pipe_halt || (accept && op == OP_HALT)) state_nxt = S_IDLE;
            end
            S_STEP: begin
                step_cnt_nxt = step_cnt - 7'd1;
                if (pipe_halt || step_cnt == 7'd1) state_nxt = S_IDLE;
            end
            S_LATCH: begin
                shift_nxt    = dbg_data;
                byte_cnt_nxt = 2'd0;
                state_nxt    = S_SEND;
            end
            S_SEND: begin
                if (tx.ready) begin
                    shift_nxt    = {8'h00, shift[31:8]};
                    byte_cnt_nxt = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Enable is registered from the next state so it rises on the accepting edge.
        en_nxt = (state_nxt == S_RUN) || (state_nxt == S_STEP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            step_cnt    <= '0;
            shift       <= '0;
            byte_cnt    <= '0;
            dbg_sel     <= '0;
            pipe_en     <= 1'b0;
            running     <= 1'b0;
            cycle_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            step_cnt <= step_cnt_nxt;
            shift    <= shift_nxt;
            byte_cnt <= byte_cnt_nxt;
            dbg_sel  <= dbg_sel_nxt;
            pipe_en  <= en_nxt;
            running  <= en_nxt;
            if (pipe_en) cycle_count <= cycle_count + CNT_W'(1);
        end
    end

endmodule
